// File: rtl/instruction_controller.sv
// Control unit for the phase-sequenced CPU: owns PC, IR, flags and the run/halt FSM,
// and turns the decoded instruction into the execute-cycle datapath control word.
module instruction_controller #(
  parameter int                    DATA_WIDTH   = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = {DATA_WIDTH{1'b0}}
) (
  input  logic                  clock,
  input  logic                  input_reset_n,
  input  logic                  input_fetch,
  input  logic                  input_decode,
  input  logic                  input_execute,
  input  logic                  input_increment,
  input  logic [DATA_WIDTH-1:0] input_memory_data,
  input  logic                  input_carry,
  input  logic                  input_zero,
  input  logic                  input_resume,
  output logic [DATA_WIDTH-1:0] output_address,
  output logic                  output_ram_read,
  output logic                  output_memory_write,
  output logic                  output_a_in,
  output logic                  output_sum_out,
  output logic                  output_alu_subtract,
  output logic                  output_immediate_out,
  output logic                  output_display_in,
  output logic                  output_clock_enable,
  output logic                  output_clear,
  output logic [DATA_WIDTH-1:0] output_pc,
  output logic                  output_halted,
  output logic                  output_phase_error
);

  localparam int OPERAND_WIDTH = DATA_WIDTH - 4;
  localparam logic [DATA_WIDTH-1:0] PC_ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam int CW_RAM_READ  = 0;
  localparam int CW_MEM_WRITE = 1;
  localparam int CW_A_IN      = 2;
  localparam int CW_SUM_OUT   = 3;
  localparam int CW_SUBTRACT  = 4;
  localparam int CW_IMMEDIATE = 5;
  localparam int CW_DISPLAY   = 6;
  localparam int CW_WIDTH     = 7;

  typedef enum logic [1:0] {
    ST_START  = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t                  state_reg;
  logic [DATA_WIDTH-1:0]   pc_reg;
  logic [DATA_WIDTH-1:0]   ir_reg;
  logic                    carry_reg;
  logic                    zero_reg;
  logic                    jump_taken_reg;
  logic                    phase_error_reg;
  logic                    clear_reg;
  logic                    clock_enable_reg;
  logic [CW_WIDTH-1:0]     cw_reg;
  logic [CW_WIDTH-1:0]     cw_next;

  logic [3:0]              opcode;
  logic [DATA_WIDTH-1:0]   operand_ext;
  logic [2:0]              strobe_count;
  logic                    single_strobe;
  logic                    multi_strobe;
  logic                    jump_next;
  logic                    use_operand;

  assign opcode      = ir_reg[DATA_WIDTH-1 -: 4];
  assign operand_ext = {4'b0000, ir_reg[OPERAND_WIDTH-1:0]};

  assign strobe_count  = {2'b00, input_fetch} + {2'b00, input_decode}
                       + {2'b00, input_execute} + {2'b00, input_increment};
  assign single_strobe = (strobe_count == 3'd1);
  assign multi_strobe  = (strobe_count > 3'd1);

  // Jump decision uses the flags as stored before this execute edge.
  assign jump_next = (opcode == OP_JMP)
                   | ((opcode == OP_JC) & carry_reg)
                   | ((opcode == OP_JZ) & zero_reg);

  always_comb begin
    cw_next = '0;
    case (opcode)
      OP_LDA: begin
        cw_next[CW_RAM_READ] = 1'b1;
        cw_next[CW_A_IN]     = 1'b1;
      end
      OP_ADD: begin
        cw_next[CW_RAM_READ] = 1'b1;
        cw_next[CW_A_IN]     = 1'b1;
        cw_next[CW_SUM_OUT]  = 1'b1;
      end
      OP_SUB: begin
        cw_next[CW_RAM_READ] = 1'b1;
        cw_next[CW_A_IN]     = 1'b1;
        cw_next[CW_SUM_OUT]  = 1'b1;
        cw_next[CW_SUBTRACT] = 1'b1;
      end
      OP_STA: cw_next[CW_MEM_WRITE] = 1'b1;
      OP_LDI: begin
        cw_next[CW_IMMEDIATE] = 1'b1;
        cw_next[CW_A_IN]      = 1'b1;
      end
      OP_OUT: cw_next[CW_DISPLAY] = 1'b1;
      default: cw_next = '0;
    endcase
  end

  always_ff @(posedge clock or negedge input_reset_n) begin
    if (!input_reset_n) begin
      state_reg        <= ST_START;
      pc_reg           <= RESET_VECTOR;
      ir_reg           <= '0;
      carry_reg        <= 1'b0;
      zero_reg         <= 1'b0;
      jump_taken_reg   <= 1'b0;
      cw_reg           <= '0;
      phase_error_reg  <= 1'b0;
      clear_reg        <= 1'b1;
      clock_enable_reg <= 1'b1;
    end else begin
      if (multi_strobe) begin
        phase_error_reg <= 1'b1;
      end
      case (state_reg)
        ST_START: begin
          state_reg        <= ST_RUN;
          clear_reg        <= 1'b0;
          clock_enable_reg <= 1'b1;
        end
        ST_RUN: begin
          if (single_strobe) begin
            if (input_fetch) begin
              ir_reg <= input_memory_data;
            end
            if (input_decode) begin
              cw_reg <= cw_next;
            end
            if (input_execute) begin
              cw_reg         <= '0;
              jump_taken_reg <= jump_next;
              if ((opcode == OP_ADD) || (opcode == OP_SUB)) begin
                carry_reg <= input_carry;
                zero_reg  <= input_zero;
              end
              // Halting here also swallows the following increment phase.
              if (opcode == OP_HLT) begin
                state_reg        <= ST_HALTED;
                clock_enable_reg <= 1'b0;
              end
            end
            if (input_increment) begin
              pc_reg         <= jump_taken_reg ? operand_ext : pc_reg + PC_ONE;
              jump_taken_reg <= 1'b0;
            end
          end
        end
        ST_HALTED: begin
          if (input_resume) begin
            pc_reg           <= pc_reg + PC_ONE;
            state_reg        <= ST_START;
            clear_reg        <= 1'b1;
            clock_enable_reg <= 1'b1;
          end
        end
        default: begin
          state_reg        <= ST_START;
          clear_reg        <= 1'b1;
          clock_enable_reg <= 1'b1;
        end
      endcase
    end
  end

  assign use_operand = input_execute && (opcode >= OP_LDA) && (opcode <= OP_LDI);

  assign output_address       = use_operand ? operand_ext : pc_reg;
  assign output_ram_read      = cw_reg[CW_RAM_READ]  & input_execute;
  assign output_memory_write  = cw_reg[CW_MEM_WRITE] & input_execute;
  assign output_a_in          = cw_reg[CW_A_IN]      & input_execute;
  assign output_sum_out       = cw_reg[CW_SUM_OUT]   & input_execute;
  assign output_alu_subtract  = cw_reg[CW_SUBTRACT]  & input_execute;
  assign output_immediate_out = cw_reg[CW_IMMEDIATE] & input_execute;
  assign output_display_in    = cw_reg[CW_DISPLAY]   & input_execute;
  assign output_clock_enable  = clock_enable_reg;
  assign output_clear         = clear_reg;
  assign output_pc            = pc_reg;
  assign output_halted        = (state_reg == ST_HALTED);
  assign output_phase_error   = phase_error_reg;

endmodule

// File: tb/tb_instruction_controller.sv
// Randomized bench for instruction_controller: an instruction-level model predicts every
// output each cycle, and a few literal expectations pin the model to known programs.
module tb_instruction_controller;

  logic       clock = 1'b0;
  logic       rst_n = 1'b0;
  logic       fetch_s, decode_s, execute_s, increment_s;
  logic [7:0] mem_data;
  logic       carry_in, zero_in, resume;

  logic [7:0] output_address, output_pc;
  logic       output_ram_read, output_memory_write, output_a_in, output_sum_out;
  logic       output_alu_subtract, output_immediate_out, output_display_in;
  logic       output_clock_enable, output_clear, output_halted, output_phase_error;
  logic [6:0] dut_ctrl;

  always #5 clock = ~clock;

  instruction_controller dut (
    .clock                (clock),
    .input_reset_n        (rst_n),
    .input_fetch          (fetch_s),
    .input_decode         (decode_s),
    .input_execute        (execute_s),
    .input_increment      (increment_s),
    .input_memory_data    (mem_data),
    .input_carry          (carry_in),
    .input_zero           (zero_in),
    .input_resume         (resume),
    .output_address       (output_address),
    .output_ram_read      (output_ram_read),
    .output_memory_write  (output_memory_write),
    .output_a_in          (output_a_in),
    .output_sum_out       (output_sum_out),
    .output_alu_subtract  (output_alu_subtract),
    .output_immediate_out (output_immediate_out),
    .output_display_in    (output_display_in),
    .output_clock_enable  (output_clock_enable),
    .output_clear         (output_clear),
    .output_pc            (output_pc),
    .output_halted        (output_halted),
    .output_phase_error   (output_phase_error)
  );

  // {ram_read, memory_write, a_in, sum_out, alu_subtract, immediate_out, display_in}
  assign dut_ctrl = {output_ram_read, output_memory_write, output_a_in, output_sum_out,
                     output_alu_subtract, output_immediate_out, output_display_in};

  // Instruction-level model state
  logic [7:0] m_pc, m_ir;
  logic       m_carry, m_zero, m_jump, m_start, m_halted, m_err;
  int         m_decoded_op;
  int         errors = 0;
  int         checks = 0;
  logic [6:0] exe_ctrl;
  logic [7:0] exe_addr;

  function automatic logic [6:0] ctrl_of(input int op);
    case (op)
      1:  return 7'b1010000;
      2:  return 7'b1011000;
      3:  return 7'b1011100;
      4:  return 7'b0100000;
      5:  return 7'b0010010;
      14: return 7'b0000001;
      default: return 7'b0000000;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at t=%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 8'h00; m_ir = 8'h00; m_carry = 1'b0; m_zero = 1'b0; m_jump = 1'b0;
    m_start = 1'b1; m_halted = 1'b0; m_err = 1'b0; m_decoded_op = -1;
  endtask

  task automatic model_update();
    int n;
    int op;
    n  = int'(fetch_s) + int'(decode_s) + int'(execute_s) + int'(increment_s);
    op = int'(m_ir[7:4]);
    if (n > 1) m_err = 1'b1;
    if (m_start) begin
      m_start = 1'b0;
    end else if (m_halted) begin
      if (resume) begin
        m_pc = m_pc + 8'd1;
        m_halted = 1'b0;
        m_start = 1'b1;
      end
    end else if (n == 1) begin
      if (fetch_s) begin
        m_ir = mem_data;
      end else if (decode_s) begin
        m_decoded_op = op;
      end else if (execute_s) begin
        m_jump = (op == 6) || (op == 7 && m_carry) || (op == 8 && m_zero);
        if (op == 2 || op == 3) begin
          m_carry = carry_in;
          m_zero  = zero_in;
        end
        if (op == 15) m_halted = 1'b1;
        m_decoded_op = -1;
      end else begin
        m_pc = m_jump ? {4'h0, m_ir[3:0]} : m_pc + 8'd1;
        m_jump = 1'b0;
      end
    end
  endtask

  task automatic compare_model();
    int         op;
    logic [6:0] exp_ctrl;
    logic [7:0] exp_addr;
    op       = int'(m_ir[7:4]);
    exp_ctrl = execute_s ? ctrl_of(m_decoded_op) : 7'b0000000;
    exp_addr = (execute_s && op >= 1 && op <= 5) ? {4'h0, m_ir[3:0]} : m_pc;
    chk("pc", 32'(output_pc), 32'(m_pc));
    chk("address", 32'(output_address), 32'(exp_addr));
    chk("controls", 32'(dut_ctrl), 32'(exp_ctrl));
    chk("clear", 32'(output_clear), 32'(m_start));
    chk("clock_enable", 32'(output_clock_enable), 32'(!m_halted));
    chk("halted", 32'(output_halted), 32'(m_halted));
    chk("phase_error", 32'(output_phase_error), 32'(m_err));
  endtask

  task automatic settle();
    #1;
    compare_model();
  endtask

  task automatic clk();
    @(posedge clock);
    if (!rst_n) model_reset();
    else model_update();
    @(negedge clock);
  endtask

  task automatic set_strobes(input logic [3:0] s);
    {fetch_s, decode_s, execute_s, increment_s} = s;
  endtask

  task automatic cycle(input logic [3:0] s, input logic [7:0] md);
    set_strobes(s);
    mem_data = md;
    settle();
    clk();
  endtask

  task automatic instr(input logic [7:0] b, input logic c, input logic z);
    cycle(4'b1000, b);
    cycle(4'b0100, 8'($urandom));
    set_strobes(4'b0010);
    carry_in = c;
    zero_in  = z;
    settle();
    exe_ctrl = dut_ctrl;
    exe_addr = output_address;
    clk();
    cycle(4'b0001, 8'($urandom));
  endtask

  task automatic idle_settle();
    set_strobes(4'b0000);
    settle();
  endtask

  initial begin
    logic [3:0] nops [6];
    logic [3:0] s;
    nops[0] = 4'h0; nops[1] = 4'h9; nops[2] = 4'hA;
    nops[3] = 4'hB; nops[4] = 4'hC; nops[5] = 4'hD;
    set_strobes(4'b0000);
    mem_data = 8'h00; carry_in = 1'b0; zero_in = 1'b0; resume = 1'b0;
    model_reset();
    @(posedge clock);
    @(negedge clock);

    // Reset held, then released: one-cycle clear
    for (int k = 0; k < 3; k++) begin
      settle();
      if (k == 0) begin
        chk("rst_pc", 32'(output_pc), 32'h00);
        chk("rst_clear", 32'(output_clear), 32'h1);
        chk("rst_ce", 32'(output_clock_enable), 32'h1);
      end
      clk();
    end
    rst_n = 1'b1;
    settle();
    chk("start_clear", 32'(output_clear), 32'h1);
    clk();
    settle();
    chk("run_clear", 32'(output_clear), 32'h0);
    chk("run_ce", 32'(output_clock_enable), 32'h1);
    clk();

    // LDI 7
    instr(8'h57, 1'b0, 1'b0);
    chk("ldi_ctrl", 32'(exe_ctrl), 32'(7'b0010010));
    chk("ldi_addr", 32'(exe_addr), 32'h07);
    idle_settle();
    chk("ldi_pc", 32'(output_pc), 32'h01);
    clk();

    // ADD sets carry -> JC taken; SUB clears carry -> JC not taken
    instr(8'h25, 1'b1, 1'b0);
    chk("add_ctrl", 32'(exe_ctrl), 32'(7'b1011000));
    instr(8'h7A, 1'b0, 1'b0);
    idle_settle();
    chk("jc_taken_pc", 32'(output_pc), 32'h0A);
    clk();
    instr(8'h31, 1'b0, 1'b0);
    instr(8'h7A, 1'b1, 1'b1);
    idle_settle();
    chk("jc_not_taken_pc", 32'(output_pc), 32'h0C);
    clk();

    // Walk PC up to FF, wrap, then JMP
    for (int k = 0; k < 243; k++) instr({nops[$urandom_range(0, 5)], 4'($urandom)}, 1'b0, 1'b0);
    idle_settle();
    chk("pc_ff", 32'(output_pc), 32'hFF);
    clk();
    instr(8'h00, 1'b0, 1'b0);
    idle_settle();
    chk("pc_wrap", 32'(output_pc), 32'h00);
    clk();
    instr(8'h6F, 1'b0, 1'b0);
    idle_settle();
    chk("jmp_pc", 32'(output_pc), 32'h0F);
    clk();

    // HLT at 03, strobes ignored, resume
    instr(8'h63, 1'b0, 1'b0);
    instr(8'hF0, 1'b0, 1'b0);
    idle_settle();
    chk("hlt_halted", 32'(output_halted), 32'h1);
    chk("hlt_ce", 32'(output_clock_enable), 32'h0);
    chk("hlt_pc", 32'(output_pc), 32'h03);
    clk();
    cycle(4'b1000, 8'h5F);
    cycle(4'b0100, 8'h00);
    cycle(4'b0010, 8'h00);
    cycle(4'b0001, 8'h00);
    idle_settle();
    chk("hlt_pc_hold", 32'(output_pc), 32'h03);
    resume = 1'b1;
    clk();
    resume = 1'b0;
    idle_settle();
    chk("resume_clear", 32'(output_clear), 32'h1);
    chk("resume_pc", 32'(output_pc), 32'h04);
    chk("resume_ce", 32'(output_clock_enable), 32'h1);
    clk();
    idle_settle();
    chk("resume_clear_off", 32'(output_clear), 32'h0);
    clk();

    // Multi-hot strobes: error set, IR kept
    instr(8'h53, 1'b0, 1'b0);
    cycle(4'b1100, 8'h1E);
    idle_settle();
    chk("perr_set", 32'(output_phase_error), 32'h1);
    clk();
    cycle(4'b0100, 8'h00);
    set_strobes(4'b0010);
    settle();
    chk("perr_ir_kept_ctrl", 32'(dut_ctrl), 32'(7'b0010010));
    chk("perr_ir_kept_addr", 32'(output_address), 32'h03);
    clk();
    cycle(4'b0001, 8'h00);
    idle_settle();
    chk("perr_sticky", 32'(output_phase_error), 32'h1);
    chk("perr_pc", 32'(output_pc), 32'h06);
    clk();

    // Randomized traffic, with one reset in the middle of an instruction
    for (int it = 0; it < 400; it++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if (it == 200) begin
        cycle(4'b1000, 8'($urandom));
        rst_n = 1'b0;
        model_reset();
        idle_settle();
        chk("midreset_perr", 32'(output_phase_error), 32'h0);
        chk("midreset_pc", 32'(output_pc), 32'h00);
        clk();
        rst_n = 1'b1;
        cycle(4'b0000, 8'h00);
      end else if (r < 65) begin
        resume = ($urandom_range(0, 7) == 0);
        instr(8'($urandom), 1'($urandom), 1'($urandom));
        resume = 1'b0;
      end else if (r < 85) begin
        s = 4'b0001 << $urandom_range(0, 3);
        if ($urandom_range(0, 15) == 0) s = 4'($urandom);
        resume = 1'($urandom);
        cycle(s, 8'($urandom));
        resume = 1'b0;
      end else begin
        resume = 1'b1;
        carry_in = 1'($urandom);
        zero_in = 1'($urandom);
        cycle(4'b0000, 8'($urandom));
        resume = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
